// File: rtl/axi_spi_req_arbiter.sv
// Arbitrates two SPI requesters and turns each grant into AXI4-Lite writes of ctrl, trans and data.
// Optional feature macro AXI_SPI_CTRL_CACHE_EN: skip the ctrl write when it matches the last one.

module axi_spi_req_arbiter #(
  parameter logic [27:0] CTRL_ADDR  = 28'd0,
  parameter logic [27:0] TRANS_ADDR = 28'd1,
  parameter logic [27:0] DATA_ADDR  = 28'd3
) (
  input  logic        clk_i,
  input  logic        reset_i,

  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_ctrl_i,
  input  logic [31:0] req0_trans_i,
  input  logic [31:0] req0_data_i,

  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_ctrl_i,
  input  logic [31:0] req1_trans_i,
  input  logic [31:0] req1_data_i,

  output logic        busy_o,
  output logic        done_o,
  output logic        done_id_o,
  output logic        err_o,

  output logic        awvalid_o,
  input  logic        awready_i,
  output logic [27:0] awaddr_o,
  output logic [0:0]  awprot_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  input  logic        bvalid_i,
  output logic        bready_o,
  input  logic [1:0]  bresp_i
);

  typedef enum logic [1:0] {StIdle, StAddr, StResp, StDone} state_e;

  localparam logic [1:0] StepCtrl  = 2'd0;
  localparam logic [1:0] StepTrans = 2'd1;
  localparam logic [1:0] StepData  = 2'd2;

  state_e      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] ctrl_q, ctrl_d;
  logic [31:0] trans_q, trans_d;
  logic [31:0] data_q, data_d;
  logic        id_q, id_d;
  logic        err_q, err_d;
  logic        last_q, last_d;

  logic        any_req;
  logic        win_id;
  logic [31:0] win_ctrl, win_trans, win_data;
  logic [1:0]  start_step;
  logic        awvalid_int, wvalid_int;
  logic        aw_hs, w_hs, b_ok;
  logic [27:0] step_addr;
  logic [31:0] step_data;

  // Round robin: on contention the requester not served last wins.
  always_comb begin
    any_req   = req0_valid_i | req1_valid_i;
    win_id    = (req0_valid_i & req1_valid_i) ? ~last_q : req1_valid_i;
    win_ctrl  = win_id ? req1_ctrl_i  : req0_ctrl_i;
    win_trans = win_id ? req1_trans_i : req0_trans_i;
    win_data  = win_id ? req1_data_i  : req0_data_i;
  end

`ifdef AXI_SPI_CTRL_CACHE_EN
  logic [31:0] cache_q, cache_d;
  logic        cache_vld_q, cache_vld_d;

  always_comb begin
    start_step = (cache_vld_q && (cache_q == win_ctrl)) ? StepTrans : StepCtrl;
  end
`else
  assign start_step = StepCtrl;
`endif

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    ctrl_d    = ctrl_q;
    trans_d   = trans_q;
    data_d    = data_q;
    id_d      = id_q;
    err_d     = err_q;
    last_d    = last_q;
`ifdef AXI_SPI_CTRL_CACHE_EN
    cache_d     = cache_q;
    cache_vld_d = cache_vld_q;
`endif

    awvalid_int = (state_q == StAddr) & ~aw_done_q;
    wvalid_int  = (state_q == StAddr) & ~w_done_q;
    aw_hs       = awvalid_int & awready_i;
    w_hs        = wvalid_int & wready_i;
    b_ok        = (bresp_i == 2'b00);

    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d   = StAddr;
          step_d    = start_step;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          ctrl_d    = win_ctrl;
          trans_d   = win_trans;
          data_d    = win_data;
          id_d      = win_id;
          last_d    = win_id;
          err_d     = 1'b0;
        end
      end
      StAddr: begin
        // Address and data channels complete independently, possibly in the same cycle.
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (bvalid_i) begin
          if (b_ok && (step_q < StepData)) begin
            state_d   = StAddr;
            step_d    = step_q + 2'd1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d = StDone;
            err_d   = err_q | ~b_ok;
          end
`ifdef AXI_SPI_CTRL_CACHE_EN
          if (!b_ok) begin
            cache_vld_d = 1'b0;
          end else if (step_q == StepCtrl) begin
            cache_d     = ctrl_q;
            cache_vld_d = 1'b1;
          end
`endif
        end
      end
      StDone: begin
        state_d = StIdle;
        step_d  = StepCtrl;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    unique case (step_q)
      StepCtrl: begin
        step_addr = CTRL_ADDR;
        step_data = ctrl_q;
      end
      StepTrans: begin
        step_addr = TRANS_ADDR;
        step_data = trans_q;
      end
      default: begin
        step_addr = DATA_ADDR;
        step_data = data_q;
      end
    endcase
  end

  // Outputs are forced quiet while reset is asserted, not only after it is sampled.
  always_comb begin
    req0_ready_o = ~reset_i & (state_q == StIdle) & any_req & ~win_id;
    req1_ready_o = ~reset_i & (state_q == StIdle) & any_req & win_id;
    busy_o       = ~reset_i & (state_q != StIdle);
    done_o       = ~reset_i & (state_q == StDone);
    done_id_o    = done_o & id_q;
    err_o        = done_o & err_q;
    awvalid_o    = ~reset_i & awvalid_int;
    wvalid_o     = ~reset_i & wvalid_int;
    bready_o     = ~reset_i & (state_q == StResp);
    awaddr_o     = (~reset_i && state_q == StAddr) ? step_addr : 28'd0;
    wdata_o      = (~reset_i && state_q == StAddr) ? step_data : 32'd0;
    awprot_o     = 1'b0;
    wstrb_o      = 4'hF;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      step_q    <= StepCtrl;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      ctrl_q    <= 32'd0;
      trans_q   <= 32'd0;
      data_q    <= 32'd0;
      id_q      <= 1'b0;
      err_q     <= 1'b0;
      last_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      ctrl_q    <= ctrl_d;
      trans_q   <= trans_d;
      data_q    <= data_d;
      id_q      <= id_d;
      err_q     <= err_d;
      last_q    <= last_d;
    end
  end

`ifdef AXI_SPI_CTRL_CACHE_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cache_q     <= 32'd0;
      cache_vld_q <= 1'b0;
    end else begin
      cache_q     <= cache_d;
      cache_vld_q <= cache_vld_d;
    end
  end
`endif

endmodule

// File: tb/tb_axi_spi_req_arbiter.sv
// Bench for axi_spi_req_arbiter: directed table, corner sequences and random traffic against
// a transaction-level model (honours AXI_SPI_CTRL_CACHE_EN when defined).

module tb_axi_spi_req_arbiter;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        req0_valid_i, req1_valid_i;
  logic        req0_ready_o, req1_ready_o;
  logic [31:0] req0_ctrl_i, req0_trans_i, req0_data_i;
  logic [31:0] req1_ctrl_i, req1_trans_i, req1_data_i;
  logic        busy_o, done_o, done_id_o, err_o;
  logic        awvalid_o, awready_i, wvalid_o, wready_i, bvalid_i, bready_o;
  logic [27:0] awaddr_o;
  logic [0:0]  awprot_o;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic [1:0]  bresp_i;

  axi_spi_req_arbiter dut (
    .clk_i(clk), .reset_i(reset_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
    .req0_ctrl_i(req0_ctrl_i), .req0_trans_i(req0_trans_i), .req0_data_i(req0_data_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
    .req1_ctrl_i(req1_ctrl_i), .req1_trans_i(req1_trans_i), .req1_data_i(req1_data_i),
    .busy_o(busy_o), .done_o(done_o), .done_id_o(done_id_o), .err_o(err_o),
    .awvalid_o(awvalid_o), .awready_i(awready_i), .awaddr_o(awaddr_o), .awprot_o(awprot_o),
    .wvalid_o(wvalid_o), .wready_i(wready_i), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
    .bvalid_i(bvalid_i), .bready_o(bready_o), .bresp_i(bresp_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_bound(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // Slave: per-channel latency in cycles, SLVERR returned for writes to err_addr.
  int aw_lat = 0, w_lat = 0, b_lat = 0, err_addr = -1;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  int last_aw = -1;
  int aw_log[$];
  logic [31:0] w_log[$];

  always @(negedge clk) begin
    if (awvalid_o) begin
      awready_i = (aw_cnt >= aw_lat);
      if (awready_i) begin
        aw_log.push_back(int'(awaddr_o));
        last_aw = int'(awaddr_o);
        aw_cnt = 0;
      end else aw_cnt++;
    end else begin
      awready_i = 1'b0;
      aw_cnt = 0;
    end
    if (wvalid_o) begin
      wready_i = (w_cnt >= w_lat);
      if (wready_i) begin
        w_log.push_back(wdata_o);
        w_cnt = 0;
      end else w_cnt++;
    end else begin
      wready_i = 1'b0;
      w_cnt = 0;
    end
    if (bready_o) begin
      bvalid_i = (b_cnt >= b_lat);
      bresp_i  = (last_aw == err_addr) ? 2'b10 : 2'b00;
      if (bvalid_i) b_cnt = 0;
      else b_cnt++;
    end else begin
      bvalid_i = 1'b0;
      bresp_i  = 2'b00;
      b_cnt = 0;
    end
  end

  // Transaction-level model: register map, round robin, abort on error, cycle cost.
  int rr_last = 1;
  int e_addr[$];
  logic [31:0] e_data[$];
  int e_lat;
  bit e_err;
`ifdef AXI_SPI_CTRL_CACHE_EN
  bit m_cache_vld = 1'b0;
  logic [31:0] m_cache = 32'd0;
`endif

  function automatic int addr_of(input int s);
    return (s == 0) ? 0 : ((s == 1) ? 1 : 3);
  endfunction

  function automatic int model_winner(input bit v0, input bit v1);
    if (v0 && v1) return (rr_last == 0) ? 1 : 0;
    return v1 ? 1 : 0;
  endfunction

  task automatic model_reset();
    rr_last = 1;
`ifdef AXI_SPI_CTRL_CACHE_EN
    m_cache_vld = 1'b0;
`endif
  endtask

  task automatic model_seq(input int id, input logic [95:0] p, input int awl, input int wl,
                           input int bl, input int erra);
    int start;
    start = 0;
    rr_last = id;
`ifdef AXI_SPI_CTRL_CACHE_EN
    if (m_cache_vld && m_cache == p[95:64]) start = 1;
`endif
    e_addr.delete();
    e_data.delete();
    e_err = 1'b0;
    e_lat = 1;
    for (int s = start; s < 3 && !e_err; s++) begin
      e_addr.push_back(addr_of(s));
      e_data.push_back(p[95 - 32 * s -: 32]);
      e_lat += ((awl > wl) ? awl : wl) + 1 + bl + 1;
      if (addr_of(s) == erra) e_err = 1'b1;
    end
`ifdef AXI_SPI_CTRL_CACHE_EN
    if (e_err) m_cache_vld = 1'b0;
    else if (start == 0) begin
      m_cache_vld = 1'b1;
      m_cache = p[95:64];
    end
`endif
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    model_reset();
  endtask

  task automatic start_seq(input bit v0, input bit v1, input logic [95:0] p0,
                           input logic [95:0] p1, output int gid, output int gcyc, output bit ok);
    aw_log.delete();
    w_log.delete();
    @(posedge clk); #1;
    req0_valid_i = v0;
    req1_valid_i = v1;
    {req0_ctrl_i, req0_trans_i, req0_data_i} = p0;
    {req1_ctrl_i, req1_trans_i, req1_data_i} = p1;
    ok = 1'b0;
    gid = -1;
    gcyc = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (req0_ready_o || req1_ready_o) begin
        ok = 1'b1;
        gid = req1_ready_o ? 1 : 0;
        gcyc = cyc;
        check("ready_onehot", req0_ready_o & req1_ready_o, 0);
      end
    end
    if (!ok) fail_bound("grant_wait");
    @(posedge clk); #1;
    // Inputs change after the grant edge; the captured payload must not follow them.
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    req0_ctrl_i = $urandom; req0_trans_i = $urandom; req0_data_i = $urandom;
    req1_ctrl_i = $urandom; req1_trans_i = $urandom; req1_data_i = $urandom;
  endtask

  task automatic finish_seq(output int dcyc, output int did, output bit derr, output bit ok);
    ok = 1'b0;
    dcyc = 0;
    did = -1;
    derr = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (done_o) begin
        ok = 1'b1;
        dcyc = cyc;
        did = int'(done_id_o);
        derr = err_o;
      end
    end
    if (!ok) fail_bound("done_wait");
  endtask

  task automatic compare_seq(input string tag, input int gid, input int did, input bit derr,
                             input int lat, input int exp_id, input int exp_nw,
                             input bit exp_err, input int exp_lat);
    check({tag, "_grant_id"}, gid, exp_id);
    check({tag, "_done_id"}, did, exp_id);
    check({tag, "_err"}, derr, exp_err);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_aw_count"}, aw_log.size(), exp_nw);
    check({tag, "_w_count"}, w_log.size(), exp_nw);
    for (int i = 0; i < e_addr.size() && i < aw_log.size() && i < w_log.size(); i++) begin
      check($sformatf("%s_awaddr%0d", tag, i), aw_log[i], e_addr[i]);
      check($sformatf("%s_wdata%0d", tag, i), w_log[i], e_data[i]);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"}, {req0_ready_o, req1_ready_o, busy_o, done_o, done_id_o, err_o,
                          awvalid_o, wvalid_o, bready_o, awprot_o}, 0);
    check({tag, "_awaddr"}, awaddr_o, 0);
    check({tag, "_wdata"}, wdata_o, 0);
    check({tag, "_wstrb"}, wstrb_o, 4'hF);
  endtask

  typedef struct {
    bit rst;
    bit v0;
    bit v1;
    int awl;
    int wl;
    int bl;
    int erra;
    int exp_id;
    int exp_nw;
    bit exp_err;
    int exp_lat;
  } vec_t;

  localparam logic [95:0] P0 = {32'h0000_0602, 32'h0000_0002, 32'h0000_0073};
  localparam logic [95:0] P1 = {32'h0000_0A05, 32'h0000_0004, 32'h0000_00C3};

  vec_t tbl[9];
  int gid, gcyc, dcyc, did, xnw, xlat, wid;
  bit ok, ok2, derr, xerr, v0, v1;
  logic [95:0] p0, p1;
  logic [31:0] c0, c1;
  int r;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rst v0 v1 awl wl bl erra  id nw err lat
    tbl[0] = '{1'b1, 1'b1, 1'b0, 0, 0, 0, -1, 0, 3, 1'b0, 7};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 0, 0, 0, -1, 0, 3, 1'b0, 7};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 0, 0, 0, -1, 1, 3, 1'b0, 7};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 0, 0, 0, -1, 0, 3, 1'b0, 7};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 0, 0, 0, -1, 1, 3, 1'b0, 7};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 0, 0, 2, -1, 1, 3, 1'b0, 13};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 1, 0, 2, 1'b1, 5};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 1, 1, 1, 3, 1, 3, 1'b1, 13};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 0, 0, 0, 0, 0, 1, 1'b1, 3};

    reset_i = 1'b1;
    req0_valid_i = 1'b1;
    req1_valid_i = 1'b0;
    {req0_ctrl_i, req0_trans_i, req0_data_i} = P0;
    {req1_ctrl_i, req1_trans_i, req1_data_i} = P1;
    repeat (2) @(negedge clk);
    check_quiet("in_reset");
    @(posedge clk); #1;
    reset_i = 1'b0;
    req0_valid_i = 1'b0;
    model_reset();
    @(negedge clk);
    check_quiet("after_reset");

    foreach (tbl[i]) begin
      if (tbl[i].rst) pulse_reset();
      aw_lat = tbl[i].awl; w_lat = tbl[i].wl; b_lat = tbl[i].bl; err_addr = tbl[i].erra;
      start_seq(tbl[i].v0, tbl[i].v1, P0, P1, gid, gcyc, ok);
      model_seq(tbl[i].exp_id, (tbl[i].exp_id == 1) ? P1 : P0, tbl[i].awl, tbl[i].wl,
                tbl[i].bl, tbl[i].erra);
      if (ok) begin
        finish_seq(dcyc, did, derr, ok2);
`ifdef AXI_SPI_CTRL_CACHE_EN
        xnw = e_addr.size(); xerr = e_err; xlat = e_lat;
`else
        xnw = tbl[i].exp_nw; xerr = tbl[i].exp_err; xlat = tbl[i].exp_lat;
`endif
        if (ok2) compare_seq($sformatf("vec%0d", i), gid, did, derr, dcyc - gcyc,
                             tbl[i].exp_id, xnw, xerr, xlat);
      end
    end

    // Skewed handshakes: each valid must drop right after its own handshake.
    for (int k = 0; k < 2; k++) begin
      aw_lat = (k == 0) ? 0 : 3; w_lat = (k == 0) ? 3 : 0; b_lat = 0; err_addr = -1;
      p0 = {32'h1111_0000 + k, 32'h2222_0000 + k, 32'h3333_0000 + k};
      start_seq(1'b1, 1'b0, p0, P1, gid, gcyc, ok);
      model_seq(0, p0, aw_lat, w_lat, 0, -1);
      if (ok) begin
        @(negedge clk);
        check($sformatf("skew%0d_both_valid", k), {awvalid_o, wvalid_o}, 2'b11);
        @(negedge clk);
        check($sformatf("skew%0d_one_dropped", k), {awvalid_o, wvalid_o},
              (k == 0) ? 2'b01 : 2'b10);
        finish_seq(dcyc, did, derr, ok2);
        if (ok2) compare_seq($sformatf("skew%0d", k), gid, did, derr, dcyc - gcyc, 0, 3,
                             1'b0, 16);
      end
    end

    // Reset while waiting for a write response.
    aw_lat = 0; w_lat = 0; b_lat = 6; err_addr = -1;
    start_seq(1'b1, 1'b0, P0, P1, gid, gcyc, ok);
    ok2 = 1'b0;
    for (int i = 0; i < 20 && !ok2; i++) begin
      @(negedge clk);
      ok2 = bready_o;
    end
    if (!ok2) fail_bound("bready_wait");
    @(posedge clk); #1;
    reset_i = 1'b1;
    @(negedge clk);
    check_quiet("mid_resp_reset");
    @(posedge clk); #1;
    reset_i = 1'b0;
    model_reset();
    b_lat = 0;
    @(negedge clk);
    check_quiet("post_mid_reset");
    start_seq(1'b0, 1'b1, P0, P1, gid, gcyc, ok);
    model_seq(1, P1, 0, 0, 0, -1);
    if (ok) begin
      finish_seq(dcyc, did, derr, ok2);
      if (ok2) compare_seq("req1_after_reset", gid, did, derr, dcyc - gcyc, 1, 3, 1'b0, 7);
    end

`ifdef AXI_SPI_CTRL_CACHE_EN
    pulse_reset();
    for (int k = 0; k < 2; k++) begin
      start_seq(1'b1, 1'b0, P0, P1, gid, gcyc, ok);
      model_seq(0, P0, 0, 0, 0, -1);
      if (ok) begin
        finish_seq(dcyc, did, derr, ok2);
        if (ok2) compare_seq($sformatf("cache%0d", k), gid, did, derr, dcyc - gcyc, 0,
                             (k == 0) ? 3 : 2, 1'b0, (k == 0) ? 7 : 5);
      end
    end
`endif

    // Random traffic against the model.
    for (int it = 0; it < 40; it++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v1 = 1'b1;
      c0 = ($urandom_range(0, 1) == 1) ? 32'h0000_0602 : $urandom;
      c1 = ($urandom_range(0, 1) == 1) ? 32'h0000_0602 : $urandom;
      p0 = {c0, $urandom, $urandom};
      p1 = {c1, $urandom, $urandom};
      aw_lat = $urandom_range(0, 3); w_lat = $urandom_range(0, 3); b_lat = $urandom_range(0, 3);
      r = $urandom_range(0, 5);
      err_addr = (r < 3) ? addr_of(r) : -1;
      wid = model_winner(v0, v1);
      start_seq(v0, v1, p0, p1, gid, gcyc, ok);
      model_seq(wid, (wid == 1) ? p1 : p0, aw_lat, w_lat, b_lat, err_addr);
      if (ok) begin
        finish_seq(dcyc, did, derr, ok2);
        if (ok2) compare_seq($sformatf("rnd%0d", it), gid, did, derr, dcyc - gcyc, wid,
                             e_addr.size(), e_err, e_lat);
      end
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_spi_req_arbiter.md
AXI_SPI_REQ_ARBITER -- requirements
Module: axi_spi_req_arbiter

Interface
REQ-001 SHALL have parameter CTRL_ADDR, default 28'd0, AXI address of the SPI control register.
REQ-002 SHALL have parameter TRANS_ADDR, default 28'd1, AXI address of the transfer-control register.
REQ-003 SHALL have parameter DATA_ADDR, default 28'd3, AXI address of the TX data register.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all logic on rising edge.
REQ-005 SHALL have port reset_i, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have ports reqN_valid_i (N=0,1), input, 1, requester N has a pending transfer.
REQ-007 SHALL have ports reqN_ready_o, output, 1, one-cycle grant/capture strobe to requester N.
REQ-008 SHALL have ports reqN_ctrl_i, reqN_trans_i, reqN_data_i, input, 32 each, payload words for requester N.
REQ-009 SHALL have port busy_o, output, 1, sequence in progress.
REQ-010 SHALL have ports done_o (1) and done_id_o (1), output, completion pulse and finished requester index.
REQ-011 SHALL have port err_o, output, 1, non-OKAY response seen; valid only with done_o.
REQ-012 SHALL have AXI4-Lite write-master ports: awvalid_o/awready_i, awaddr_o[27:0], awprot_o[0:0], wvalid_o/wready_i, wdata_o[31:0], wstrb_o[3:0], bvalid_i/bready_o, bresp_i[1:0].

Function
REQ-013 SHALL use FSM states IDLE, ADDR, RESP, DONE, and a step counter of 0=ctrl, 1=trans, 2=data.
REQ-014 SHALL, in IDLE with any reqN_valid_i high, assert the winner's reqN_ready_o combinationally, latch its three words and index on that edge, and enter ADDR at step 0.
REQ-015 SHALL arbitrate round-robin: if both requesters are valid, the one not granted last wins; after reset, req0 wins.
REQ-016 SHALL, in ADDR, drive awaddr_o/wdata_o for the current step and assert awvalid_o and wvalid_o together on ADDR entry.
REQ-017 SHALL drop awvalid_o and wvalid_o independently after their own handshake, and enter RESP once both have completed, including when both complete in the same cycle.
REQ-018 SHALL hold bready_o high only in RESP; on bvalid_i, bresp_i==2'b00 with step<2 goes to ADDR with step+1, and all other cases go to DONE.
REQ-019 SHALL abort remaining steps on any non-OKAY bresp_i and set the error flag for the current sequence.
REQ-020 SHALL, in DONE, pulse done_o for one cycle with done_id_o and err_o, then return to IDLE; a new grant is possible on the following cycle.
REQ-021 SHALL drive awprot_o to constant 0 and wstrb_o to constant 4'hF.
REQ-022 SHALL hold busy_o high in ADDR, RESP and DONE.
REQ-023 SHALL keep address/data stable while the corresponding valid is high; latched payload is unaffected by requester input changes after grant.
REQ-024 SHALL give a minimum latency of 7 cycles from grant to done_o with zero-wait slave (3×(ADDR+RESP) + DONE).

Reset
REQ-025 SHALL, on reset_i, go to IDLE at any state, including mid-handshake, with step=0 and round-robin pointer reset to favour req0.
REQ-026 SHALL drive every output to 0 during and after reset until a new grant (reqN_ready_o, busy_o, done_o, done_id_o, err_o, awvalid_o, wvalid_o, bready_o, awaddr_o, wdata_o), except wstrb_o, which is 4'hF.
REQ-027 SHALL clear the control-cache valid flag on reset.

Configuration
REQ-028 SHALL, when macro AXI_SPI_CTRL_CACHE_EN is defined, keep the last OKAY-written control word plus a valid flag, and skip step 0 (start at step 1) when the granted ctrl word equals the cached value; on an error the cache is invalidated.
REQ-029 SHALL, when AXI_SPI_CTRL_CACHE_EN is not defined, always perform all three writes and instantiate no cache storage.

Verification
REQ-030 SHALL cover single request: req0 ctrl=32'h0602, trans=32'h0002, data=32'h0073, zero-wait slave -> writes (0,0602),(1,0002),(3,0073) in order; done_o 7 cycles after grant; done_id_o=0; err_o=0.
REQ-031 SHALL cover contention: both valid every cycle for 4 sequences -> grants alternate 0,1,0,1.
REQ-032 SHALL cover skewed handshake: awready_i 3 cycles before wready_i, and the reverse -> each valid drops after its own handshake, and no duplicate writes occur.
REQ-033 SHALL cover error abort: bresp_i=2'b10 on trans write -> data write never issued; done_o with err_o=1.
REQ-034 SHALL cover reset mid-RESP -> outputs zero next cycle; a later req1 gets a full 3-write sequence.
REQ-035 SHALL cover the cache build: with AXI_SPI_CTRL_CACHE_EN, two back-to-back requests with ctrl=32'h0602 -> second issues only addrs 1 and 3, done 5 cycles after grant.
